ascii_frame_sender: RTL and testbench
=====================================

ASCII_FRAME_SENDER -- requirements
Module: ascii_frame_sender

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits per frame, range 1..16.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10416: clk cycles per UART bit, minimum 2.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 50000000: post-frame lockout length in cycles.
REQ-004 SHALL have parameter APPEND_CRLF, default 1: when 1, CR then LF follow the digits.
REQ-005 SHALL have parameter HEX_MODE, default 1: when 1, digit values 10..15 are sent as 'A'..'F'; when 0, they are sent as '?'.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port transmit, input, 1: level request; a rising edge starts a frame.
REQ-009 SHALL have port digits, input, 4*NUM_DIGITS: nibble i is at bits [4i+3:4i].
REQ-010 SHALL have port txd, output, 1: UART 8N1 serial line, idle high.
REQ-011 SHALL have port busy, output, 1: high from frame start through end of holdoff.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the last stop bit completes.

Function
REQ-013 SHALL register transmit each cycle; start = transmit & ~transmit_q, valid only in IDLE.
REQ-014 SHALL snapshot digits into an internal register on the start cycle; later digits changes do not affect the frame in flight.
REQ-015 SHALL use states IDLE, SEND, HOLDOFF; IDLE->SEND on start; SEND->HOLDOFF after the last byte's stop bit; HOLDOFF->IDLE after HOLDOFF_CYCLES cycles.
REQ-016 SHALL send bytes in the order digit 0, digit 1, ..., digit NUM_DIGITS-1, then 0x0D, 0x0A if APPEND_CRLF=1.
REQ-017 SHALL map each nibble d as follows: d<=9 -> 0x30+d; d>=10 -> 0x41+(d-10) if HEX_MODE=1, else 0x3F.
REQ-018 SHALL frame each byte as a start bit (0), data bits LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-019 SHALL drive the start bit on txd in the cycle after the start cycle (latency 1).
REQ-020 SHALL begin the next byte's start bit in the cycle immediately after the previous stop bit ends; no idle gap between bytes.
REQ-021 SHALL make the total SEND duration exactly (NUM_DIGITS+2*APPEND_CRLF)*10*CLKS_PER_BIT cycles.
REQ-022 SHALL ignore transmit edges during SEND and HOLDOFF; transmit_q keeps tracking, so a transmit still held high after HOLDOFF does not retrigger.
REQ-023 SHALL assert done in the same cycle the FSM moves SEND->HOLDOFF.
REQ-024 SHALL hold busy=1 in SEND and HOLDOFF, and busy=0 in IDLE.
REQ-025 SHALL treat HOLDOFF_CYCLES=0 as one cycle in HOLDOFF.

Reset
REQ-026 SHALL, while rst=1, force: state IDLE, txd=1, busy=0, done=0, transmit_q=1, and all counters to 0.
REQ-027 SHALL abort any frame when rst is asserted mid-frame, driving txd=1 on the next edge with no partial-byte completion.
REQ-028 SHALL not start a frame from a transmit level already high when rst deasserts, since transmit_q resets to 1.

Structure
REQ-029 SHALL keep state encodings, the ASCII constants (0x30, 0x41, 0x3F, 0x0D, 0x0A) and the nibble-to-ASCII function in shared package uart_pkg.
REQ-030 SHALL instantiate one sub-module, uart_tx_byte, with ports clk, rst, start, data[7:0], txd, ready, parameterised by CLKS_PER_BIT; ascii_frame_sender handles sequencing only.
REQ-031 SHALL size counters with $clog2 of their maximum value; no integer-typed registers.

Verification (NUM_DIGITS=4, CLKS_PER_BIT=4, HOLDOFF_CYCLES=20 unless stated)
REQ-032 SHALL cover basic frame: digits=16'h4321, transmit rises -> txd decodes bytes 0x31,0x32,0x33,0x34,0x0D,0x0A; done pulses once at cycle 241 after start; busy falls 20 cycles later.
REQ-033 SHALL cover hex mapping: digits=16'hFA90 -> bytes 0x30,0x39,0x41,0x46,0x0D,0x0A; with HEX_MODE=0 -> 0x30,0x39,0x3F,0x3F,0x0D,0x0A.
REQ-034 SHALL cover snapshot and ignore: digits is changed and transmit is toggled during SEND and HOLDOFF -> frame content unchanged and exactly one done pulse.
REQ-035 SHALL cover held transmit: transmit held high for 1000 cycles -> exactly one frame; a later fall and rise -> a second frame.
REQ-036 SHALL cover mid-frame reset: rst pulsed at cycle 50 of SEND -> txd=1 next cycle, busy=0, done never asserts; a new edge afterwards -> a complete correct frame.
REQ-037 SHALL cover configuration: APPEND_CRLF=0, NUM_DIGITS=1, digits=4'h7 -> single byte 0x37; SEND lasts 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART/ASCII definitions: frame FSM states, ASCII constants and nibble encoder.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_HOLDOFF = 2'd2
    } frame_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Decimal digits map to '0'..'9'; 10..15 map to 'A'..'F' or '?' depending on hex.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] d, input logic hex);
        if (d <= 4'd9) begin
            return ASCII_ZERO + {4'h0, d};
        end else if (hex) begin
            return ASCII_A + {4'h0, d} - 8'd10;
        end else begin
            return ASCII_QMARK;
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready is high when idle or in the final cycle of the stop bit,
// so a new start in that cycle chains bytes without an idle gap.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'd9;

    logic             active;
    logic [CLK_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;
    logic             bit_end;

    assign bit_end = (clk_cnt == CLK_LAST);
    assign ready   = !active || (bit_end && bit_idx == STOP_IDX);

    // shreg holds the remaining data bits with the stop bit parked above them
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            txd     <= 1'b1;
        end else if (start && ready) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
            txd     <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (bit_idx == STOP_IDX) begin
                    active <= 1'b0;
                    txd    <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascii_frame_sender.sv
// Sends a frame of ASCII-encoded nibbles (optionally followed by CR LF) over UART
// on each rising edge of transmit, then locks out new requests for a holdoff period.
module ascii_frame_sender
    import uart_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLKS_PER_BIT   = 10416,
    parameter int unsigned HOLDOFF_CYCLES = 50000000,
    parameter int unsigned APPEND_CRLF    = 1,
    parameter int unsigned HEX_MODE       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    transmit,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    txd,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned NUM_BYTES = NUM_DIGITS + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned HO_LAST   = (HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1;
    localparam int unsigned HO_W      = (HO_LAST > 0) ? $clog2(HO_LAST + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);
    localparam logic [HO_W-1:0]  HO_END     = HO_W'(HO_LAST);
    localparam logic [IDX_W:0]   DIGIT_LAST = (IDX_W + 1)'(NUM_DIGITS);

    frame_state_t            state, state_next;
    logic                    transmit_q;
    logic                    start;
    logic [4*NUM_DIGITS-1:0] snap;
    logic [IDX_W-1:0]        byte_idx;
    logic [HO_W-1:0]         ho_cnt;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_ready;
    logic                    done_next;
    logic [IDX_W:0]          sel_idx;
    logic [4*NUM_DIGITS-1:0] sel_src;
    logic [3:0]              sel_nib;

    assign start = transmit && !transmit_q && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEND;
                    tx_start   = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (byte_idx == IDX_LAST) begin
                        state_next = ST_HOLDOFF;
                        done_next  = 1'b1;
                    end else begin
                        tx_start = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt == HO_END) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The first byte comes from live digits (snapshot not yet loaded); later bytes from the snapshot
    always_comb begin
        sel_idx = '0;
        sel_src = digits;
        sel_nib = '0;
        if (state == ST_SEND) begin
            sel_idx = (IDX_W + 1)'(byte_idx) + 1'b1;
            sel_src = snap;
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_idx == (IDX_W + 1)'(i)) begin
                sel_nib = sel_src[4*i +: 4];
            end
        end
        if (sel_idx < DIGIT_LAST) begin
            tx_data = nibble_to_ascii(sel_nib, HEX_MODE != 0);
        end else if (sel_idx == DIGIT_LAST) begin
            tx_data = ASCII_CR;
        end else begin
            tx_data = ASCII_LF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            transmit_q <= 1'b1;
            snap       <= '0;
            byte_idx   <= '0;
            ho_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            transmit_q <= transmit;
            done       <= done_next;
            busy       <= (state_next != ST_IDLE);
            if (start) begin
                snap <= digits;
            end
            if (state != ST_SEND) begin
                byte_idx <= '0;
            end else if (tx_start) begin
                byte_idx <= byte_idx + 1'b1;
            end
            ho_cnt <= (state == ST_HOLDOFF) ? ho_cnt + 1'b1 : '0;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .txd  (txd),
        .ready(tx_ready)
    );

endmodule

// File: tb/tb_ascii_frame_sender.sv
// Directed bench for ascii_frame_sender: default hex config, HEX_MODE=0 config and
// a single-digit no-CRLF config, decoding txd cycle by cycle.
module tb_ascii_frame_sender;

    localparam int CPB = 4;
    localparam int HO  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        transmit_a, transmit_b, transmit_c;
    logic [15:0] digits;
    logic [3:0]  digits_c;
    logic        txd_a, busy_a, done_a;
    logic        txd_b, busy_b, done_b;
    logic        txd_c, busy_c, done_c;

    int          vectors = 0;
    int          miscompares = 0;
    int          sel = 0;
    logic        txd_s, busy_s, done_s;
    int          done_cnt [3] = '{0, 0, 0};
    logic [7:0]  exp_bytes [6];

    always #5 clk = ~clk;

    ascii_frame_sender #(.NUM_DIGITS(4), .CLKS_PER_BIT(CPB), .HOLDOFF_CYCLES(HO),
                         .APPEND_CRLF(1), .HEX_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .transmit(transmit_a), .digits(digits),
        .txd(txd_a), .busy(busy_a), .done(done_a));

    ascii_frame_sender #(.NUM_DIGITS(4), .CLKS_PER_BIT(CPB), .HOLDOFF_CYCLES(HO),
                         .APPEND_CRLF(1), .HEX_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .transmit(transmit_b), .digits(digits),
        .txd(txd_b), .busy(busy_b), .done(done_b));

    ascii_frame_sender #(.NUM_DIGITS(1), .CLKS_PER_BIT(CPB), .HOLDOFF_CYCLES(HO),
                         .APPEND_CRLF(0), .HEX_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .transmit(transmit_c), .digits(digits_c),
        .txd(txd_c), .busy(busy_c), .done(done_c));

    always_comb begin
        case (sel)
            1:       begin txd_s = txd_b; busy_s = busy_b; done_s = done_b; end
            2:       begin txd_s = txd_c; busy_s = busy_c; done_s = done_c; end
            default: begin txd_s = txd_a; busy_s = busy_a; done_s = done_a; end
        endcase
    end

    always @(negedge clk) begin
        if (done_a) done_cnt[0] <= done_cnt[0] + 1;
        if (done_b) done_cnt[1] <= done_cnt[1] + 1;
        if (done_c) done_cnt[2] <= done_cnt[2] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_transmit(input int s, input logic v);
        case (s)
            1:       transmit_b = v;
            2:       transmit_c = v;
            default: transmit_a = v;
        endcase
    endtask

    // Leaves the bench 1 time unit into the start cycle of a new frame
    task automatic pulse_start(input int s);
        tick();
        set_transmit(s, 1'b0);
        tick();
        set_transmit(s, 1'b1);
    endtask

    // Called in the start cycle; returns at the first IDLE cycle after holdoff
    task automatic frame_check(input string tag, input int nbytes);
        logic [9:0] bits;
        bit         stable;
        bit         early_done;
        int         busy_hits;
        bits       = '0;
        early_done = 1'b0;
        @(negedge clk);
        check($sformatf("%s_start_cycle_txd", tag), 32'(txd_s), 32'd1);
        for (int b = 0; b < nbytes; b++) begin
            stable = 1'b1;
            for (int j = 0; j < 10; j++) begin
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk);
                    if (done_s) early_done = 1'b1;
                    if (k == 0) bits[j] = txd_s;
                    else if (txd_s !== bits[j]) stable = 1'b0;
                end
            end
            check($sformatf("%s_byte%0d{stable,start,stop,data}", tag, b),
                  32'({stable, bits[0], bits[9], bits[8:1]}),
                  32'({1'b1, 1'b0, 1'b1, exp_bytes[b]}));
        end
        check($sformatf("%s_no_early_done", tag), 32'(early_done), 32'd0);
        @(negedge clk);
        check($sformatf("%s_done_at_end", tag), 32'({done_s, busy_s, txd_s}), 32'b111);
        busy_hits = 0;
        for (int i = 1; i < HO; i++) begin
            @(negedge clk);
            if (busy_s && !done_s) busy_hits++;
        end
        check($sformatf("%s_holdoff_busy_cycles", tag), 32'(busy_hits), 32'(HO - 1));
        @(negedge clk);
        check($sformatf("%s_idle_after_holdoff", tag), 32'(busy_s), 32'd0);
    endtask

    initial begin
        int d0;
        int busy_hits;
        int low_hits;

        rst        = 1'b1;
        transmit_a = 1'b0;
        transmit_b = 1'b0;
        transmit_c = 1'b0;
        digits     = 16'h0000;
        digits_c   = 4'h0;
        repeat (3) tick();
        check("reset_outputs_a", 32'({txd_a, busy_a, done_a}), 32'b100);
        check("reset_outputs_c", 32'({txd_c, busy_c, done_c}), 32'b100);
        rst = 1'b0;
        tick();

        // Basic frame
        sel       = 0;
        digits    = 16'h4321;
        exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        transmit_a = 1'b1;
        frame_check("basic", 6);
        check("basic_done_count", 32'(done_cnt[0]), 32'd1);

        // Hex digits
        digits    = 16'hFA90;
        exp_bytes = '{8'h30, 8'h39, 8'h41, 8'h46, 8'h0D, 8'h0A};
        pulse_start(0);
        frame_check("hex", 6);

        // Non-hex mapping
        sel       = 1;
        exp_bytes = '{8'h30, 8'h39, 8'h3F, 8'h3F, 8'h0D, 8'h0A};
        pulse_start(1);
        frame_check("nohex", 6);
        transmit_b = 1'b0;

        // Snapshot and ignored edges
        sel       = 0;
        digits    = 16'h4321;
        exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        d0        = done_cnt[0];
        pulse_start(0);
        fork
            frame_check("snap", 6);
            begin
                repeat (10) tick();
                digits = 16'hFFFF;
                for (int i = 0; i < 34; i++) begin
                    repeat (7) tick();
                    transmit_a = ~transmit_a;
                end
                transmit_a = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("snap_done_count", 32'(done_cnt[0] - d0), 32'd1);

        // Held transmit: one frame only, then a fresh edge gives another
        digits = 16'h4321;
        d0     = done_cnt[0];
        pulse_start(0);
        frame_check("held1", 6);
        busy_hits = 0;
        repeat (740) begin
            @(negedge clk);
            if (busy_a) busy_hits++;
        end
        check("held_no_retrigger_busy", 32'(busy_hits), 32'd0);
        check("held_done_count", 32'(done_cnt[0] - d0), 32'd1);
        pulse_start(0);
        frame_check("held2", 6);

        // Mid-frame reset at SEND cycle 50 (data bit 1 of '0' is low)
        digits = 16'h0000;
        pulse_start(0);
        repeat (50) tick();
        check("midreset_txd_before", 32'(txd_a), 32'd0);
        rst = 1'b1;
        tick();
        check("midreset_outputs", 32'({txd_a, busy_a, done_a}), 32'b100);
        rst        = 1'b0;
        transmit_a = 1'b0;
        d0         = done_cnt[0];
        low_hits   = 0;
        repeat (300) begin
            @(negedge clk);
            if (!txd_a || busy_a) low_hits++;
        end
        check("midreset_line_idle", 32'(low_hits), 32'd0);
        check("midreset_no_done", 32'(done_cnt[0] - d0), 32'd0);
        digits = 16'h4321;
        pulse_start(0);
        frame_check("after_reset", 6);

        // Transmit already high when reset releases
        tick();
        transmit_a = 1'b1;
        rst        = 1'b1;
        repeat (2) tick();
        rst       = 1'b0;
        busy_hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy_a) busy_hits++;
        end
        check("reset_high_transmit_no_start", 32'(busy_hits), 32'd0);
        transmit_a = 1'b0;

        // Single digit, no CR/LF
        sel          = 2;
        digits_c     = 4'h7;
        exp_bytes[0] = 8'h37;
        pulse_start(2);
        frame_check("single", 1);
        check("single_done_count", 32'(done_cnt[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
